// File: rtl/insmem_prefetch_unit.sv
// Instruction-fetch front end: keeps one sequential fetch in flight to instruction memory and
// buffers the responses, each tagged with its PC, in a DEPTH-entry queue; redirects flush it.
module insmem_prefetch_unit #(
  parameter int unsigned          DATAWIDTH  = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATAWIDTH-1:0] PC_RESET   = '0,
  parameter logic [DATAWIDTH-1:0] INSMEMSTEP = DATAWIDTH'(4)
) (
  input  logic                         IPU_Clk_In,
  input  logic                         IPU_Reset_In,
  output logic                         IPU_Insmem_Ready_Out,
  output logic [DATAWIDTH-1:0]         IPU_Insmem_Addr_OutBUS,
  input  logic                         IPU_Insmem_Valid_In,
  input  logic [DATAWIDTH-1:0]         IPU_Insmem_Readdata_InBUS,
  output logic                         IPU_Ins_Valid_Out,
  input  logic                         IPU_Ins_Ready_In,
  output logic [DATAWIDTH-1:0]         IPU_Ins_OutBUS,
  output logic [DATAWIDTH-1:0]         IPU_Ins_Pc_OutBUS,
  input  logic                         IPU_Redirect_In,
  input  logic [DATAWIDTH-1:0]         IPU_Redirect_Addr_InBUS,
  output logic [$clog2(DEPTH+1)-1:0]   IPU_Count_OutBUS
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DISCARD} state_e;

  state_e                              state_q, state_d;
  logic [DATAWIDTH-1:0]                pc_q, pc_d, addr_q, addr_d;
  logic [PW-1:0]                       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                       count_q, count_d, occ_after;
  logic [DEPTH-1:0][DATAWIDTH-1:0]     ins_q, ipc_q;
  logic                                push, pop, flush;

  assign occ_after = count_q + CW'(1) - CW'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = (count_q != '0) && IPU_Ins_Ready_In && !IPU_Redirect_In;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ: begin
        if (IPU_Insmem_Valid_In && !IPU_Redirect_In) begin
          push    = 1'b1;
          pc_d    = pc_q + INSMEMSTEP;
          state_d = (occ_after < CW'(DEPTH)) ? REQ : FULL;
        end
      end
      FULL:    if (pop) state_d = REQ;
      DISCARD: if (IPU_Insmem_Valid_In) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // A redirect with a request still in flight must wait out that stale response.
    if (IPU_Redirect_In) begin
      flush   = 1'b1;
      pc_d    = IPU_Redirect_Addr_InBUS & ~DATAWIDTH'(3);
      state_d = ((state_q == REQ || state_q == DISCARD) && !IPU_Insmem_Valid_In) ? DISCARD : REQ;
    end
    addr_d  = (state_d == DISCARD) ? addr_q : pc_d;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge IPU_Clk_In) begin
    if (IPU_Reset_In) begin
      state_q  <= IDLE;
      pc_q     <= PC_RESET;
      addr_q   <= PC_RESET;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ins_q    <= '0;
      ipc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          ins_q[wr_ptr_q] <= IPU_Insmem_Readdata_InBUS;
          ipc_q[wr_ptr_q] <= pc_q;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign IPU_Insmem_Ready_Out   = (state_q == REQ) || (state_q == DISCARD);
  assign IPU_Insmem_Addr_OutBUS = addr_q;
  assign IPU_Ins_Valid_Out      = (count_q != '0);
  assign IPU_Ins_OutBUS         = ins_q[rd_ptr_q];
  assign IPU_Ins_Pc_OutBUS      = ipc_q[rd_ptr_q];
  assign IPU_Count_OutBUS       = count_q;

endmodule
